sd_cmd_sequencer_wbm: RTL and testbench

//  Wishbone master that drives the SD controller FIFO slave's register map to run one SD command.

---
 rtl/sd_cmd_sequencer_wbm_if.sv | 30 +++
 rtl/sd_cmd_sequencer_wbm.sv | 201 ++++++++++++++++++++
 tb/tb_sd_cmd_sequencer_wbm.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_cmd_sequencer_wbm_if.sv
// Wishbone link between sd_cmd_sequencer_wbm (master) and the SD controller FIFO slave.
// Signals:
//   m_wb_adr_o [2:0]  register address      (master -> slave)
//   m_wb_dat_o [7:0]  write data            (master -> slave)
//   m_wb_dat_i [7:0]  read data             (slave  -> master)
//   m_wb_sel_o [3:0]  byte select           (master -> slave)
//   m_wb_we_o         write enable          (master -> slave)
//   m_wb_cyc_o        bus cycle             (master -> slave)
//   m_wb_stb_o        strobe                (master -> slave)
//   m_wb_ack_i        acknowledge           (slave  -> master)
interface sd_cmd_sequencer_wbm_if;
  logic [2:0] m_wb_adr_o;
  logic [7:0] m_wb_dat_o;
  logic [7:0] m_wb_dat_i;
  logic [3:0] m_wb_sel_o;
  logic       m_wb_we_o;
  logic       m_wb_cyc_o;
  logic       m_wb_stb_o;
  logic       m_wb_ack_i;

  modport master (
    output m_wb_adr_o, m_wb_dat_o, m_wb_sel_o, m_wb_we_o, m_wb_cyc_o, m_wb_stb_o,
    input  m_wb_dat_i, m_wb_ack_i
  );

  modport slave (
    input  m_wb_adr_o, m_wb_dat_o, m_wb_sel_o, m_wb_we_o, m_wb_cyc_o, m_wb_stb_o,
    output m_wb_dat_i, m_wb_ack_i
  );
endinterface

// File: rtl/sd_cmd_sequencer_wbm.sv
// Wishbone master that runs one SD command through the SD controller FIFO slave.
// Frames {01,index}, argument, {CRC7,1} into 6 bytes, writes them to tx_cmd_fifo (adr 0)
// pacing on the status register (adr 4), then reads response bytes from rx_cmd_fifo
// (adr 1) under a response watchdog. Every bus access has its own ack watchdog.
// Ports:
//   wb_clk_i, wb_rst_i          clock, asynchronous active-high reset
//   cmd_start_i                 start pulse (ignored while busy_o)
//   cmd_index_i, cmd_arg_i      SD command index and argument
//   rsp_type_i                  0 none, 1/3 short (6 B), 2 long (17 B)
//   abort_i                     abort request
//   busy_o, done_o, err_code_o  status; err 0 ok, 1 rsp timeout, 2 ack timeout, 3 aborted
//   rsp_byte_o, rsp_valid_o     response byte stream, one strobe per byte
//   m_wb                        Wishbone master port
module sd_cmd_sequencer_wbm #(
  parameter logic [15:0] RSP_TMO = 16'd50000,
  parameter logic [7:0]  ACK_TMO = 8'd64
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          cmd_start_i,
  input  logic [5:0]                    cmd_index_i,
  input  logic [31:0]                   cmd_arg_i,
  input  logic [1:0]                    rsp_type_i,
  input  logic                          abort_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [1:0]                    err_code_o,
  output logic [7:0]                    rsp_byte_o,
  output logic                          rsp_valid_o,
  sd_cmd_sequencer_wbm_if.master        m_wb
);

  localparam logic [2:0] AdrTx   = 3'd0;
  localparam logic [2:0] AdrRx   = 3'd1;
  localparam logic [2:0] AdrStat = 3'd4;

  typedef enum logic [2:0] {StIdle, StWrPoll, StWrByte, StRdPoll, StRdByte, StDone} state_e;

  state_e      state_q;
  logic [39:0] frame_q;
  logic [6:0]  crc_q;
  logic [5:0]  crc_cnt_q;
  logic [2:0]  ptr_q;
  logic [4:0]  rx_cnt_q;
  logic [1:0]  rsp_type_q;
  logic [15:0] tmo_q;
  logic [7:0]  ack_cnt_q;
  logic        abort_q;

  logic        crc_rdy, crc_fb, rd_phase, abort_req, rx_last, wait_crc, acc_we;
  logic [5:0]  crc_idx;
  logic [7:0]  tx_byte;
  logic [2:0]  acc_adr;
  logic [1:0]  fin_code;

  assign m_wb.m_wb_sel_o = 4'b0001;

  always_comb begin
    crc_rdy   = (crc_cnt_q == 6'd40);
    crc_idx   = 6'd39 - crc_cnt_q;
    crc_fb    = crc_rdy ? 1'b0 : (frame_q[crc_idx] ^ crc_q[6]);
    rd_phase  = (state_q == StRdPoll) || (state_q == StRdByte);
    abort_req = abort_q | abort_i;
    rx_last   = (rx_cnt_q == ((rsp_type_q == 2'd2) ? 5'd16 : 5'd5));
    // The CRC byte may not be ready yet when the last frame byte is due.
    wait_crc  = (state_q == StWrByte) && (ptr_q == 3'd5) && !crc_rdy;
    fin_code  = abort_req ? 2'd3 : ((rd_phase && tmo_q == 16'd0) ? 2'd1 : 2'd0);
    case (ptr_q)
      3'd0:    tx_byte = frame_q[39:32];
      3'd1:    tx_byte = frame_q[31:24];
      3'd2:    tx_byte = frame_q[23:16];
      3'd3:    tx_byte = frame_q[15:8];
      3'd4:    tx_byte = frame_q[7:0];
      default: tx_byte = {crc_q, 1'b1};
    endcase
    case (state_q)
      StWrByte: begin acc_adr = AdrTx; acc_we = 1'b1; end
      StRdByte: begin acc_adr = AdrRx; acc_we = 1'b0; end
      default:  begin acc_adr = AdrStat; acc_we = 1'b0; end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q           <= StIdle;
      frame_q           <= '0;
      crc_q             <= '0;
      crc_cnt_q         <= '0;
      ptr_q             <= '0;
      rx_cnt_q          <= '0;
      rsp_type_q        <= '0;
      tmo_q             <= '0;
      ack_cnt_q         <= '0;
      abort_q           <= 1'b0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      err_code_o        <= 2'd0;
      rsp_byte_o        <= '0;
      rsp_valid_o       <= 1'b0;
      m_wb.m_wb_adr_o   <= '0;
      m_wb.m_wb_dat_o   <= '0;
      m_wb.m_wb_we_o    <= 1'b0;
      m_wb.m_wb_cyc_o   <= 1'b0;
      m_wb.m_wb_stb_o   <= 1'b0;
    end else begin
      done_o      <= 1'b0;
      rsp_valid_o <= 1'b0;

      // Serial CRC7 (x^7 + x^3 + 1), one frame bit per cycle, MSB first.
      if (state_q != StIdle && !crc_rdy) begin
        crc_q     <= {crc_q[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);
        crc_cnt_q <= crc_cnt_q + 6'd1;
      end
      if (state_q != StIdle && abort_i) abort_q <= 1'b1;
      if (rd_phase && tmo_q != 16'd0) tmo_q <= tmo_q - 16'd1;

      case (state_q)
        StIdle: begin
          if (cmd_start_i) begin
            state_q    <= StWrPoll;
            busy_o     <= 1'b1;
            err_code_o <= 2'd0;
            ptr_q      <= '0;
            frame_q    <= {2'b01, cmd_index_i, cmd_arg_i};
            crc_q      <= '0;
            crc_cnt_q  <= '0;
            rsp_type_q <= rsp_type_i;
            abort_q    <= 1'b0;
          end
        end
        StWrPoll, StWrByte, StRdPoll, StRdByte: begin
          if (m_wb.m_wb_cyc_o) begin
            if (m_wb.m_wb_ack_i) begin
              m_wb.m_wb_cyc_o <= 1'b0;
              m_wb.m_wb_stb_o <= 1'b0;
              m_wb.m_wb_we_o  <= 1'b0;
              case (state_q)
                StWrPoll: state_q <= m_wb.m_wb_dat_i[0] ? StWrPoll : StWrByte;
                StWrByte: begin
                  ptr_q <= ptr_q + 3'd1;
                  if (ptr_q != 3'd5) begin
                    state_q <= StWrPoll;
                  end else if (rsp_type_q == 2'd0) begin
                    state_q    <= StDone;
                    done_o     <= 1'b1;
                    err_code_o <= fin_code;
                  end else begin
                    state_q  <= StRdPoll;
                    tmo_q    <= RSP_TMO;
                    rx_cnt_q <= '0;
                  end
                end
                StRdPoll: state_q <= m_wb.m_wb_dat_i[1] ? StRdPoll : StRdByte;
                default: begin
                  rsp_byte_o  <= m_wb.m_wb_dat_i;
                  rsp_valid_o <= 1'b1;
                  rx_cnt_q    <= rx_cnt_q + 5'd1;
                  // An expired watchdog stays expired so the error is still raised.
                  if (tmo_q != 16'd0) tmo_q <= RSP_TMO;
                  if (rx_last) begin
                    state_q    <= StDone;
                    done_o     <= 1'b1;
                    err_code_o <= fin_code;
                  end else begin
                    state_q <= StRdPoll;
                  end
                end
              endcase
            end else if (ack_cnt_q == ACK_TMO - 8'd1) begin
              m_wb.m_wb_cyc_o <= 1'b0;
              m_wb.m_wb_stb_o <= 1'b0;
              m_wb.m_wb_we_o  <= 1'b0;
              state_q         <= StDone;
              done_o          <= 1'b1;
              err_code_o      <= 2'd2;
            end else begin
              ack_cnt_q <= ack_cnt_q + 8'd1;
            end
          end else if (abort_req || (rd_phase && tmo_q == 16'd0)) begin
            // Bus idle here, so pending abort/timeout can end the command.
            state_q    <= StDone;
            done_o     <= 1'b1;
            err_code_o <= fin_code;
          end else if (!wait_crc) begin
            m_wb.m_wb_cyc_o <= 1'b1;
            m_wb.m_wb_stb_o <= 1'b1;
            m_wb.m_wb_adr_o <= acc_adr;
            m_wb.m_wb_we_o  <= acc_we;
            m_wb.m_wb_dat_o <= acc_we ? tx_byte : 8'h00;
            ack_cnt_q       <= '0;
          end
        end
        default: begin
          busy_o  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_sequencer_wbm.sv
// Directed bench for sd_cmd_sequencer_wbm with a behavioural FIFO slave and scoreboard queues.
module tb_sd_cmd_sequencer_wbm;
  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        cmd_start_i = 1'b0;
  logic [5:0]  cmd_index_i = '0;
  logic [31:0] cmd_arg_i = '0;
  logic [1:0]  rsp_type_i = '0;
  logic        abort_i = 1'b0;
  logic        busy_o, done_o, rsp_valid_o;
  logic [1:0]  err_code_o;
  logic [7:0]  rsp_byte_o;

  sd_cmd_sequencer_wbm_if bus ();

  sd_cmd_sequencer_wbm #(.RSP_TMO(16'd100), .ACK_TMO(8'd64)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .cmd_start_i (cmd_start_i),
    .cmd_index_i (cmd_index_i),
    .cmd_arg_i   (cmd_arg_i),
    .rsp_type_i  (rsp_type_i),
    .abort_i     (abort_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_code_o  (err_code_o),
    .rsp_byte_o  (rsp_byte_o),
    .rsp_valid_o (rsp_valid_o),
    .m_wb        (bus)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  int wr_cnt = 0;
  int rd1_cnt = 0;
  int rsp_cnt = 0;
  int t_wr6 = 0;
  int gap = 0;
  logic tx_full = 1'b0;
  logic ack_hold = 1'b0;
  logic gap_en = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_wr[$];
  logic [7:0] exp_rsp[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc_end(input logic [39:0] bits);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = bits[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return {c, 1'b1};
  endfunction

  task automatic push_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] b;
    b = {2'b01, idx, arg};
    for (int i = 4; i >= 0; i--) exp_wr.push_back(b[i*8 +: 8]);
    exp_wr.push_back(crc_end(b));
  endtask

  // Behavioural FIFO slave: status bit0 = tx full, bit1 = rx empty.
  always @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      bus.m_wb_ack_i <= 1'b0;
      bus.m_wb_dat_i <= '0;
      gap            <= 0;
    end else begin
      if (gap > 0) gap <= gap - 1;
      if (bus.m_wb_cyc_o && bus.m_wb_stb_o && !bus.m_wb_ack_i && !ack_hold) begin
        bus.m_wb_ack_i <= 1'b1;
        if (!bus.m_wb_we_o) begin
          if (bus.m_wb_adr_o == 3'd4) begin
            bus.m_wb_dat_i <= {6'd0, (rx_q.size() == 0 || gap > 0), tx_full};
          end else if (rx_q.size() > 0) begin
            bus.m_wb_dat_i <= rx_q.pop_front();
            if (gap_en) gap <= int'($urandom_range(0, 50));
          end else begin
            bus.m_wb_dat_i <= 8'hEE;
          end
        end
      end else begin
        bus.m_wb_ack_i <= 1'b0;
      end
    end
  end

  always @(posedge wb_clk_i) cyc_n++;

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge wb_clk_i) begin
    if (!wb_rst_i && bus.m_wb_cyc_o && bus.m_wb_stb_o && bus.m_wb_ack_i) begin
      if (bus.m_wb_we_o) begin
        wr_cnt++;
        if (wr_cnt == 6) t_wr6 = cyc_n;
        check("wr_adr", bus.m_wb_adr_o, 0);
        check("wr_byte", bus.m_wb_dat_o, exp_wr.size() > 0 ? {24'd0, exp_wr.pop_front()} : 32'h100);
      end else if (bus.m_wb_adr_o == 3'd1) begin
        rd1_cnt++;
      end
    end
    if (!wb_rst_i && rsp_valid_o) begin
      rsp_cnt++;
      check("rsp_byte", rsp_byte_o, exp_rsp.size() > 0 ? {24'd0, exp_rsp.pop_front()} : 32'h100);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge wb_clk_i);
  endtask

  task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt);
    cmd_index_i = idx;
    cmd_arg_i   = arg;
    rsp_type_i  = rt;
    cmd_start_i = 1'b1;
    tick(1);
    cmd_start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done_o && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, done_o, 1);
  endtask

  task automatic wait_wr(input int target);
    int n;
    n = 0;
    while (wr_cnt < target && n < 500) begin
      tick(1);
      n++;
    end
    check("wr_reach", wr_cnt >= target, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    int n;
    logic [7:0] b;

    // Reset state
    tick(3);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_code_o, 0);
    check("rst_rspv", rsp_valid_o, 0);
    check("rst_rspb", rsp_byte_o, 0);
    check("rst_cyc", bus.m_wb_cyc_o, 0);
    check("rst_stb", bus.m_wb_stb_o, 0);
    check("rst_we", bus.m_wb_we_o, 0);
    check("rst_adr", bus.m_wb_adr_o, 0);
    check("rst_dat", bus.m_wb_dat_o, 0);
    check("rst_sel", bus.m_wb_sel_o, 4'b0001);
    wb_rst_i = 1'b0;
    tick(2);

    // CMD0, no response
    exp_wr = {8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
    wr_cnt = 0;
    rd1_cnt = 0;
    start_cmd(6'd0, 32'h0, 2'd0);
    check("cmd0_busy", busy_o, 1);
    wait_done("cmd0_done", 500);
    check("cmd0_err", err_code_o, 0);
    tick(1);
    check("cmd0_idle", busy_o, 0);
    check("cmd0_wrs", wr_cnt, 6);
    check("cmd0_rd1", rd1_cnt, 0);
    check("cmd0_left", exp_wr.size(), 0);

    // CMD8, short response; a second start while busy must be ignored
    exp_wr  = {8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87};
    rx_q    = {8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h13};
    exp_rsp = {8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h13};
    rsp_cnt = 0;
    start_cmd(6'd8, 32'h0000_01AA, 2'd1);
    tick(3);
    start_cmd(6'd63, 32'hFFFF_FFFF, 2'd2);
    wait_done("cmd8_done", 1000);
    check("cmd8_err", err_code_o, 0);
    tick(2);
    check("cmd8_rsps", rsp_cnt, 6);
    check("cmd8_left", exp_rsp.size(), 0);

    // CMD2, long response with random rx-empty gaps
    push_frame(6'd2, 32'h0);
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      rx_q.push_back(b);
      exp_rsp.push_back(b);
    end
    gap_en = 1'b1;
    rsp_cnt = 0;
    start_cmd(6'd2, 32'h0, 2'd2);
    wait_done("cmd2_done", 4000);
    check("cmd2_err", err_code_o, 0);
    tick(2);
    gap_en = 1'b0;
    check("cmd2_rsps", rsp_cnt, 17);

    // tx full held mid-frame
    push_frame(6'd17, 32'h1234_5678);
    wr_cnt = 0;
    start_cmd(6'd17, 32'h1234_5678, 2'd0);
    wait_wr(2);
    tx_full = 1'b1;
    tick(200);
    check("txf_stall", wr_cnt, 2);
    check("txf_busy", busy_o, 1);
    tx_full = 1'b0;
    wait_done("txf_done", 500);
    check("txf_err", err_code_o, 0);
    tick(1);
    check("txf_wrs", wr_cnt, 6);
    check("txf_left", exp_wr.size(), 0);

    // Response timeout with no bytes
    push_frame(6'd55, 32'h0);
    wr_cnt = 0;
    rsp_cnt = 0;
    start_cmd(6'd55, 32'h0, 2'd1);
    wait_done("tmo_done", 800);
    check("tmo_err", err_code_o, 1);
    check("tmo_window", (cyc_n - t_wr6 >= 95) && (cyc_n - t_wr6 <= 115), 1);
    check("tmo_rsps", rsp_cnt, 0);
    tick(2);

    // Ack withheld
    ack_hold = 1'b1;
    start_cmd(6'd0, 32'h0, 2'd0);
    n = 0;
    while (!bus.m_wb_stb_o && n < 50) begin
      tick(1);
      n++;
    end
    t0 = cyc_n;
    wait_done("ack_done", 200);
    check("ack_err", err_code_o, 2);
    check("ack_window", (cyc_n - t0 >= 63) && (cyc_n - t0 <= 66), 1);
    check("ack_cyc", bus.m_wb_cyc_o, 0);
    ack_hold = 1'b0;
    tick(2);

    // Abort while polling for the response
    push_frame(6'd8, 32'h0000_01AA);
    wr_cnt = 0;
    rd1_cnt = 0;
    start_cmd(6'd8, 32'h0000_01AA, 2'd1);
    wait_wr(6);
    tick(5);
    abort_i = 1'b1;
    tick(1);
    abort_i = 1'b0;
    wait_done("abt_done", 20);
    check("abt_err", err_code_o, 3);
    check("abt_rd1", rd1_cnt, 0);
    tick(2);

    // Abort in IDLE is ignored
    abort_i = 1'b1;
    tick(1);
    abort_i = 1'b0;
    tick(1);
    push_frame(6'd0, 32'h0);
    start_cmd(6'd0, 32'h0, 2'd0);
    wait_done("idab_done", 500);
    check("idab_err", err_code_o, 0);
    tick(2);

    // Reset in the middle of a write
    push_frame(6'd0, 32'h0);
    start_cmd(6'd0, 32'h0, 2'd0);
    n = 0;
    while (!(bus.m_wb_stb_o && bus.m_wb_we_o) && n < 100) begin
      tick(1);
      n++;
    end
    check("mid_wr", bus.m_wb_we_o, 1);
    wb_rst_i = 1'b1;
    #1;
    check("mid_cyc", bus.m_wb_cyc_o, 0);
    check("mid_stb", bus.m_wb_stb_o, 0);
    check("mid_we", bus.m_wb_we_o, 0);
    check("mid_dat", bus.m_wb_dat_o, 0);
    check("mid_busy", busy_o, 0);
    check("mid_done", done_o, 0);
    tick(2);
    wb_rst_i = 1'b0;
    exp_wr.delete();
    tick(2);
    push_frame(6'd0, 32'h0);
    wr_cnt = 0;
    start_cmd(6'd0, 32'h0, 2'd0);
    wait_done("post_done", 500);
    check("post_err", err_code_o, 0);
    tick(1);
    check("post_wrs", wr_cnt, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
